// File: rtl/blink_pulse_counter_if.sv
// Bus bundle for blink_pulse_counter: pulse/enable/clear inputs and the
// count and display outputs. The master drives inputs, the slave is the counter.
interface blink_pulse_counter_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  pulse_in;
    logic                  en;
    logic                  clear;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  overflow;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     dig_sel;

    modport master (
        output pulse_in, en, clear,
        input  count_bcd, overflow, seg, dig_sel
    );

    modport slave (
        input  pulse_in, en, clear,
        output count_bcd, overflow, seg, dig_sel
    );
endinterface

// File: rtl/blink_pulse_counter.sv
// Counts rising edges of an asynchronous blink signal in a BCD counter and
// shows the count on a time-multiplexed common-anode 7-segment display.
module blink_pulse_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic                  clk,
    input logic                  rst,
    blink_pulse_counter_if.slave bus
);
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                s1, s2, s3;
    logic                rise;
    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_inc;
    logic                carry;
    logic                overflow_q;
    logic [PRE_W-1:0]    pre_q;
    logic [IDX_W-1:0]    idx_q;
    logic [3:0]          cur_digit;
    logic [6:0]          seg_d, seg_q;
    logic [DIGITS-1:0]   dig_d, dig_q;

    // Synchronizer: deliberately not reset so a level held through rst never
    // looks like an edge once rst drops.
    always_ff @(posedge clk) begin
        s1 <= bus.pulse_in;
        s2 <= s1;
        s3 <= s2;
    end

    assign rise = s2 & ~s3 & ~rst;

    // BCD increment with ripple carry; carry out means every digit was 9.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Count and sticky overflow, priority rst > clear > counted edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (rise && bus.en) begin
            count_q <= count_inc;
            if (carry) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Decode the selected digit to active-low {g..a} and its active-low enable.
    always_comb begin
        cur_digit = count_q[{idx_q, 2'b00} +: 4];
        case (cur_digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b1111111;
        endcase
        dig_d = ~(DIGITS'(1) << idx_q);
    end

    // Registered display outputs; seg and dig_sel load together so they always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'h7F;
            dig_q <= {DIGITS{1'b1}};
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.seg       = seg_q;
    assign bus.dig_sel   = dig_q;
endmodule

// File: tb/tb_blink_pulse_counter.sv
// Bench for blink_pulse_counter: vector table, directed corner sequences and
// random stimulus, all checked against a decimal-arithmetic reference model.
module tb_blink_pulse_counter;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int          MAXV     = 9999;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blink_pulse_counter_if #(.DIGITS(DIGITS)) bus ();

    blink_pulse_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: decimal count, sticky flag, cycles since reset release.
    int         m_count = 0;
    bit         m_ovf   = 1'b0;
    int         m_t     = 0;
    logic [6:0] m_seg   = 7'h7F;
    logic [3:0] m_dig   = 4'hF;
    bit         hist[$] = '{1'b0, 1'b0, 1'b0};

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic        rst;
        logic        pulse;
        logic        en;
        logic        clear;
        logic [15:0] cnt;
        logic        ovf;
        logic [6:0]  seg;
        logic [3:0]  dig;
    } vec_t;

    vec_t tab [20];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int idx);
        int x;
        x = v;
        for (int i = 0; i < idx; i++) x = x / 10;
        return x % 10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs sampled at this edge, then compare.
    task automatic step();
        int  idx;
        bit  rise_seen;
        @(posedge clk);
        if (rst) begin
            m_seg = 7'h7F;
            m_dig = 4'hF;
            m_t   = 0;
        end else begin
            idx   = (m_t / SCAN_DIV) % DIGITS;
            m_dig = ~(4'(1) << idx);
            m_seg = seg_tab[digit_of(m_count, idx)];
            m_t++;
        end
        hist.push_back(bus.pulse_in);
        // An edge on pulse_in sampled two edges ago counts at this edge.
        rise_seen = hist[hist.size()-3] && !hist[hist.size()-4];
        if (rst) begin
            m_count = 0;
            m_ovf   = 1'b0;
        end else if (bus.clear) begin
            m_count = 0;
            m_ovf   = 1'b0;
        end else if (rise_seen && bus.en) begin
            if (m_count == MAXV) begin
                m_count = 0;
                m_ovf   = 1'b1;
            end else begin
                m_count++;
            end
        end
        if (hist.size() > 8) void'(hist.pop_front());
        #1;
        chk("model_count", 32'(bus.count_bcd), 32'(to_bcd(m_count)));
        chk("model_ovf",   32'(bus.overflow),  32'(m_ovf));
        chk("model_seg",   32'(bus.seg),       32'(m_seg));
        chk("model_dig",   32'(bus.dig_sel),   32'(m_dig));
    endtask

    task automatic give_edge();
        bus.pulse_in = 1'b1;
        step();
        step();
        bus.pulse_in = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] scan_seg [4];
        logic [3:0] scan_dig [4];
        logic [3:0] prev_dig;
        bit         found;
        int         exp_v;

        // rst, pulse, en, clear -> count, ovf, seg, dig (state after that edge)
        tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h7F, 4'hF};
        tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h7F, 4'hF};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h7F, 4'hF};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hE};
        tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hE};
        tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hE};
        tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hE};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hD};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hD};
        tab[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hD};
        tab[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hD};
        tab[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 7'h40, 4'hB};
        tab[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 7'h40, 4'hB};
        tab[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 7'h40, 4'hB};
        tab[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 7'h40, 4'hB};
        tab[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 7'h40, 4'h7};
        tab[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 7'h40, 4'h7};
        tab[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 7'h40, 4'h7};
        tab[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 7'h40, 4'h7};
        tab[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 7'h40, 4'hE};

        scan_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
        scan_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

        rst          = 1'b1;
        bus.pulse_in = 1'b0;
        bus.en       = 1'b0;
        bus.clear    = 1'b0;

        // Reset, idle, en=0 discard, clear beats a same-cycle edge.
        for (int i = 0; i < 20; i++) begin
            rst          = tab[i].rst;
            bus.pulse_in = tab[i].pulse;
            bus.en       = tab[i].en;
            bus.clear    = tab[i].clear;
            step();
            chk($sformatf("tab%0d_count", i), 32'(bus.count_bcd), 32'(tab[i].cnt));
            chk($sformatf("tab%0d_ovf", i),   32'(bus.overflow),  32'(tab[i].ovf));
            chk($sformatf("tab%0d_seg", i),   32'(bus.seg),       32'(tab[i].seg));
            chk($sformatf("tab%0d_dig", i),   32'(bus.dig_sel),   32'(tab[i].dig));
        end
        bus.clear = 1'b0;

        // Latency: count moves exactly two edges after pulse_in rises.
        do_reset();
        bus.en = 1'b1;
        exp_v  = 0;
        for (int r = 0; r < 12; r++) begin
            bus.pulse_in = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                if (i == 1) chk("lat_hold", 32'(bus.count_bcd), 32'(to_bcd(exp_v)));
                if (i == 2) begin
                    exp_v++;
                    chk("lat_step", 32'(bus.count_bcd), 32'(to_bcd(exp_v)));
                end
            end
            bus.pulse_in = 1'b0;
            repeat (6) step();
        end
        chk("lat_final", 32'(bus.count_bcd), 32'h0012);

        // Wrap from all-9s and sticky overflow.
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        repeat (9998) give_edge();
        chk("wrap_9998", 32'(bus.count_bcd), 32'h9998);
        give_edge();
        chk("wrap_9999", 32'(bus.count_bcd), 32'h9999);
        chk("wrap_no_ovf", 32'(bus.overflow), 32'd0);
        give_edge();
        chk("wrap_zero", 32'(bus.count_bcd), 32'h0000);
        chk("wrap_ovf", 32'(bus.overflow), 32'd1);
        repeat (3) give_edge();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("after_wrap", 32'(bus.count_bcd), 32'h0003);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_count", 32'(bus.count_bcd), 32'h0000);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);

        // Level held high through reset must not count.
        bus.pulse_in = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (6) step();
        chk("rst_hold_high", 32'(bus.count_bcd), 32'h0000);
        bus.pulse_in = 1'b0;
        repeat (2) step();
        bus.pulse_in = 1'b1;
        repeat (3) step();
        chk("first_real_edge", 32'(bus.count_bcd), 32'h0001);
        bus.pulse_in = 1'b0;
        repeat (2) step();

        // Scan order with count 1234.
        do_reset();
        repeat (1234) give_edge();
        chk("scan_count", 32'(bus.count_bcd), 32'h1234);
        found    = 1'b0;
        prev_dig = bus.dig_sel;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (prev_dig == 4'h7 && bus.dig_sel == 4'hE) found = 1'b1;
            prev_dig = bus.dig_sel;
        end
        chk("scan_align", 32'(found), 32'd1);
        for (int j = 0; j < 32; j++) begin
            chk("scan_dig", 32'(bus.dig_sel), 32'(scan_dig[(j / 4) % 4]));
            chk("scan_seg", 32'(bus.seg),     32'(scan_seg[(j / 4) % 4]));
            step();
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) bus.pulse_in = ~bus.pulse_in;
            bus.en    = ($urandom_range(0, 7) != 0);
            bus.clear = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
